// File: rtl/baud_tick_gen.sv
// ============================================================================
// baud_tick_gen
// ----------------------------------------------------------------------------
// Programmable baud-rate tick generator for the RS-232 TX/RX pair.
//
// A sample counter divides the system clock by a runtime-loadable divisor and
// emits sample_tick_o once per sample period (consumed by the receiver). An
// oversample counter divides the sample ticks by OvsRatio and emits
// bit_tick_o (consumed by the transmitter).
//
// New divisors go through a shadow register and are applied only on a period
// boundary, on a clear, or while the counter is disabled. A period that is
// already running is never shortened or truncated by a load.
//
// Optional feature (compile-time macro BAUD_TICK_GEN_FRAC_EN):
//   Adds a FracWidth-bit fractional accumulator. Each sample tick adds the
//   active fraction; a carry out stretches the following sample period by one
//   clock, so the average period is div + frac/2^FracWidth. Without the macro
//   frac_i is ignored and every period is exactly div_o clocks.
//
// Parameters:
//   Width       width of the divisor and the sample counter
//   DefaultDiv  divisor active out of reset (>= 2, < 2^Width)
//   OvsRatio    sample ticks per bit tick (>= 2)
//   FracWidth   width of the fractional divisor field
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_ni         asynchronous active-low reset
//   en_i           count enable; counters hold while low
//   clr_i          synchronous clear of both counters (wins over en_i)
//   div_i          new divisor value (0 and 1 are clamped to 2)
//   frac_i         new fractional divisor (fractional build only)
//   div_load_i     one-cycle strobe capturing div_i/frac_i into the shadow
//   div_o          active divisor after clamping
//   cnt_o          current sample counter value
//   sample_tick_o  one-cycle pulse at the end of each sample period
//   bit_tick_o     one-cycle pulse on every OvsRatio-th sample tick
//   load_pend_o    shadow divisor waiting to be applied
// ============================================================================
module baud_tick_gen #(
    parameter int unsigned Width      = 16,
    parameter int unsigned DefaultDiv = 326,
    parameter int unsigned OvsRatio   = 16,
    parameter int unsigned FracWidth  = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic [Width-1:0]     div_i,
    input  logic [FracWidth-1:0] frac_i,
    input  logic                 div_load_i,
    output logic [Width-1:0]     div_o,
    output logic [Width-1:0]     cnt_o,
    output logic                 sample_tick_o,
    output logic                 bit_tick_o,
    output logic                 load_pend_o
);

    localparam int unsigned OvsWidth = (OvsRatio > 1) ? $clog2(OvsRatio) : 1;

    localparam logic [Width-1:0]    DefaultDivW = Width'(DefaultDiv);
    localparam logic [Width-1:0]    MinDiv      = Width'(2);
    localparam logic [OvsWidth-1:0] OvsLast     = OvsWidth'(OvsRatio - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [Width-1:0]    cnt_q;
    logic [OvsWidth-1:0] ovs_q;
    logic [Width-1:0]    div_act_q;
    logic [Width-1:0]    div_shadow_q;
    logic                load_pend_q;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic             stretch;        // current period is div_act + 1 clocks
    logic [Width-1:0] last_cnt;       // period - 1
    logic             at_end;
    logic             sample_tick;
    logic             bit_tick;
    logic [Width-1:0] div_clamped;
    logic [Width-1:0] div_src;
    logic             apply_window;
    logic             apply_now;

    // div_act >= 2 always, so div_act - 1 + stretch never overflows Width.
    assign last_cnt = div_act_q - Width'(1) + Width'(stretch);

    // The terminal test uses >= rather than == so that a divisor shrunk
    // while the counter is frozen above the new end point wraps on the next
    // enabled cycle instead of running all the way round 2^Width. In normal
    // counting cnt never exceeds last_cnt, so this is an equality check.
    assign at_end = (cnt_q >= last_cnt);

    assign sample_tick = en_i & ~clr_i & at_end;
    assign bit_tick    = sample_tick & (ovs_q == OvsLast);

    assign div_clamped = (div_i < MinDiv) ? MinDiv : div_i;

    // A load arriving in the same cycle as an apply opportunity bypasses the
    // shadow so it takes effect on the very next cycle.
    assign div_src = div_load_i ? div_clamped : div_shadow_q;

    // Moments when changing the divisor cannot disturb a running period:
    // the wrap edge itself, a clear, or any disabled cycle.
    assign apply_window = sample_tick | clr_i | ~en_i;
    assign apply_now    = (div_load_i | load_pend_q) & apply_window;

    // ------------------------------------------------------------------------
    // Sample counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            if (sample_tick) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + Width'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Oversample counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovs_q <= '0;
        end else if (clr_i) begin
            ovs_q <= '0;
        end else if (sample_tick) begin
            if (ovs_q == OvsLast) begin
                ovs_q <= '0;
            end else begin
                ovs_q <= ovs_q + OvsWidth'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Divisor shadow / active registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_shadow_q <= DefaultDivW;
            div_act_q    <= DefaultDivW;
            load_pend_q  <= 1'b0;
        end else begin
            // Last write wins: every strobe overwrites the shadow.
            if (div_load_i) begin
                div_shadow_q <= div_clamped;
            end
            if (apply_now) begin
                div_act_q   <= div_src;
                load_pend_q <= 1'b0;
            end else if (div_load_i) begin
                load_pend_q <= 1'b1;
            end
        end
    end

`ifdef BAUD_TICK_GEN_FRAC_EN
    // ------------------------------------------------------------------------
    // Fractional accumulator
    // ------------------------------------------------------------------------
    logic [FracWidth-1:0] frac_shadow_q;
    logic [FracWidth-1:0] frac_act_q;
    logic [FracWidth-1:0] acc_q;
    logic                 stretch_q;
    logic [FracWidth-1:0] frac_src;
    logic [FracWidth-1:0] acc_sum;
    logic                 acc_carry;

    assign frac_src = div_load_i ? frac_i : frac_shadow_q;
    assign {acc_carry, acc_sum} = {1'b0, acc_q} + {1'b0, frac_act_q};

    // The fraction travels with the divisor through the same shadow path.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frac_shadow_q <= '0;
            frac_act_q    <= '0;
        end else begin
            if (div_load_i) begin
                frac_shadow_q <= frac_i;
            end
            if (apply_now) begin
                frac_act_q <= frac_src;
            end
        end
    end

    // The carry produced at the end of one period stretches the next one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else if (clr_i) begin
            acc_q     <= '0;
            stretch_q <= 1'b0;
        end else if (sample_tick) begin
            acc_q     <= acc_sum;
            stretch_q <= acc_carry;
        end
    end

    assign stretch = stretch_q;
`else
    // Integer-only build: every period is exactly div_act clocks.
    logic unused_frac;
    assign unused_frac = ^frac_i;
    assign stretch     = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign div_o         = div_act_q;
    assign cnt_o         = cnt_q;
    assign sample_tick_o = sample_tick;
    assign bit_tick_o    = bit_tick;
    assign load_pend_o   = load_pend_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// ============================================================================
// tb_baud_tick_gen
// ----------------------------------------------------------------------------
// Directed bench for baud_tick_gen (Width=16, DefaultDiv=326, OvsRatio=16,
// FracWidth=4). Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge or 1+ time units after the rising edge.
// Define BAUD_TICK_GEN_FRAC_EN for both files to exercise the fractional path.
// ============================================================================
module tb_baud_tick_gen;

    // ------------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------------
    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        load;
    logic [15:0] div_in;
    logic [3:0]  frac_in;
    logic [15:0] div_out;
    logic [15:0] cnt_out;
    logic        sample_tick;
    logic        bit_tick;
    logic        load_pend;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    baud_tick_gen #(
        .Width      (16),
        .DefaultDiv (326),
        .OvsRatio   (16),
        .FracWidth  (4)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .clr_i         (clr),
        .div_i         (div_in),
        .frac_i        (frac_in),
        .div_load_i    (load),
        .div_o         (div_out),
        .cnt_o         (cnt_out),
        .sample_tick_o (sample_tick),
        .bit_tick_o    (bit_tick),
        .load_pend_o   (load_pend)
    );

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic drive(input bit e, input bit c, input bit l,
                         input int d, input int f);
        en      = e;
        clr     = c;
        load    = l;
        div_in  = 16'(d);
        frac_in = 4'(f);
    endtask

    // Advance k rising edges, ending 1 unit after the last edge.
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Apply a divisor/fraction while disabled, then clear the counters with
    // en=1. Leaves cnt=0, en=1, no load pending.
    task automatic idle_load(input int d, input int f);
        drive(1'b0, 1'b0, 1'b1, d, f);
        step(1);
        drive(1'b1, 1'b1, 1'b0, 0, 0);
        step(1);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    // Count cycles (current cycle = 1) until the selected tick is seen;
    // returns -1 if the budget runs out. Ends 1 unit after the tick's edge.
    task automatic wait_tick(input bit use_bit, input int max_cyc, output int n);
        bit hit;
        n = -1;
        for (int i = 1; i <= max_cyc && n < 0; i++) begin
            @(negedge clk);
            hit = use_bit ? bit_tick : sample_tick;
            @(posedge clk);
            #1;
            if (hit) n = i;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        step(2);
        @(negedge clk);
        check("rst_cnt", cnt_out, 0);
        check("rst_div", div_out, 326);
        check("rst_sample_tick", sample_tick, 0);
        check("rst_bit_tick", bit_tick, 0);
        check("rst_load_pend", load_pend, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Vector table for the boundary-load sequence
    // ------------------------------------------------------------------------
    typedef struct {
        bit en;
        bit clr;
        bit load;
        int div;
        int exp_cnt;
        bit exp_tick;
        bit exp_pend;
        int exp_div;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input bit e, input bit c, input bit l, input int d,
                                input int ec, input bit et, input bit ep, input int ed);
        vec_t v;
        v.en = e; v.clr = c; v.load = l; v.div = d;
        v.exp_cnt = ec; v.exp_tick = et; v.exp_pend = ep; v.exp_div = ed;
        return v;
    endfunction

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------------
    initial begin
        int n;
        int sum;
        int held_bad;
        int ticks_seen;
        int pend_seen;
        int clamp_in [4];
        int clamp_exp[4];
        logic [15:0] exp_p;

        // Running at div 10, load 4 at cnt=3: pending until the cnt=9 tick,
        // then 4-cycle periods.
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 10);
        vecs[1]  = mk(1, 0, 0, 0, 1, 0, 0, 10);
        vecs[2]  = mk(1, 0, 0, 0, 2, 0, 0, 10);
        vecs[3]  = mk(1, 0, 1, 4, 3, 0, 0, 10);
        vecs[4]  = mk(1, 0, 0, 0, 4, 0, 1, 10);
        vecs[5]  = mk(1, 0, 0, 0, 5, 0, 1, 10);
        vecs[6]  = mk(1, 0, 0, 0, 6, 0, 1, 10);
        vecs[7]  = mk(1, 0, 0, 0, 7, 0, 1, 10);
        vecs[8]  = mk(1, 0, 0, 0, 8, 0, 1, 10);
        vecs[9]  = mk(1, 0, 0, 0, 9, 1, 1, 10);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 0, 4);
        vecs[11] = mk(1, 0, 0, 0, 1, 0, 0, 4);
        vecs[12] = mk(1, 0, 0, 0, 2, 0, 0, 4);
        vecs[13] = mk(1, 0, 0, 0, 3, 1, 0, 4);
        vecs[14] = mk(1, 0, 0, 0, 0, 0, 0, 4);
        vecs[15] = mk(1, 0, 0, 0, 1, 0, 0, 4);
        vecs[16] = mk(1, 0, 0, 0, 2, 0, 0, 4);
        vecs[17] = mk(1, 0, 0, 0, 3, 1, 0, 4);

        clamp_in  = '{7, 0, 9, 1};
        clamp_exp = '{7, 2, 9, 2};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 0, 0);

        // ---------------- Reset / default rate ----------------
        do_reset();
        wait_tick(1'b0, 400, n);
        check("first_sample_tick_cycle", n, 326);
        wait_tick(1'b0, 400, n);
        check("second_sample_tick_spacing", n, 326);
        wait_tick(1'b1, 6000, n);
        check("first_bit_tick_remaining", n, 16 * 326 - 2 * 326);

        // ---------------- Boundary load (table) ----------------
        idle_load(10, 0);
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].div, 0);
            @(negedge clk);
            check($sformatf("vec%0d_cnt", i), cnt_out, vecs[i].exp_cnt);
            check($sformatf("vec%0d_tick", i), sample_tick, vecs[i].exp_tick);
            check($sformatf("vec%0d_pend", i), load_pend, vecs[i].exp_pend);
            check($sformatf("vec%0d_div", i), div_out, vecs[i].exp_div);
            @(posedge clk);
            #1;
        end
        drive(1'b1, 1'b0, 1'b0, 0, 0);

        // ---------------- Enable hold at cnt=5 for 7 cycles ----------------
        idle_load(10, 0);
        step(5);
        held_bad   = 0;
        ticks_seen = 0;
        drive(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (7) begin
            @(negedge clk);
            if (cnt_out != 16'd5) held_bad++;
            if (sample_tick) ticks_seen++;
            @(posedge clk);
            #1;
        end
        check("hold_cnt_not_5_cycles", held_bad, 0);
        check("hold_ticks_seen", ticks_seen, 0);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        wait_tick(1'b0, 20, n);
        check("hold_resume_to_tick", n, 5);

        // ---------------- Clear together with load(6) ----------------
        step(9);
        drive(1'b1, 1'b1, 1'b1, 6, 0);
        @(negedge clk);
        check("clr_cycle_tick_suppressed", sample_tick, 0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        #1;
        check("clr_cnt", cnt_out, 0);
        check("clr_load_div", div_out, 6);
        check("clr_load_pend", load_pend, 0);
        wait_tick(1'b0, 20, n);
        check("clr_next_tick", n, 6);

        // ---------------- Clamp and idle load ----------------
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, clamp_in[i], 0);
            step(1);
            drive(1'b0, 1'b0, 1'b0, 0, 0);
            #1;
            check($sformatf("idle_load%0d_div", i), div_out, clamp_exp[i]);
            check($sformatf("idle_load%0d_pend", i), load_pend, 0);
        end
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        pend_seen = 0;
        for (int i = 0; i < 3; i++) begin
            wait_tick(1'b0, 10, n);
            if (load_pend) pend_seen++;
            check($sformatf("clamp_period%0d", i), n, 2);
        end
        check("clamp_pend_seen", pend_seen, 0);

        // ---------------- Last write wins ----------------
        idle_load(10, 0);
        step(2);
        drive(1'b1, 1'b0, 1'b1, 4, 0);
        step(1);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        step(1);
        drive(1'b1, 1'b0, 1'b1, 5, 0);
        step(1);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        #1;
        check("lww_pend_high", load_pend, 1);
        check("lww_div_still_old", div_out, 10);
        wait_tick(1'b0, 20, n);
        check("lww_old_period_rest", n, 5);
        check("lww_div_new", div_out, 5);
        check("lww_pend_cleared", load_pend, 0);
        wait_tick(1'b0, 20, n);
        check("lww_new_period", n, 5);

        // ---------------- Async reset mid-count ----------------
        idle_load(250, 0);
        step(200);
        check("async_cnt_before", cnt_out, 200);
        drive(1'b1, 1'b0, 1'b1, 30, 0);
        step(1);
        drive(1'b1, 1'b0, 1'b0, 0, 0);
        #1;
        check("async_pend_before", load_pend, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_cnt_zero", cnt_out, 0);
        check("async_div_default", div_out, 326);
        check("async_pend_zero", load_pend, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_tick(1'b0, 400, n);
        check("async_full_period_after_reset", n, 326);

        // ---------------- Fractional division ----------------
        idle_load(10, 4);
`ifdef BAUD_TICK_GEN_FRAC_EN
        exp_q = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd11, 16'd10, 16'd10, 16'd10};
`else
        exp_q = '{16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10, 16'd10};
`endif
        sum = 0;
        for (int i = 0; i < 8; i++) begin
            exp_p = exp_q.pop_front();
            wait_tick(1'b0, 30, n);
            check($sformatf("frac_period%0d", i), n, int'(exp_p));
            if (i >= 1 && i <= 4) sum += n;
        end
`ifdef BAUD_TICK_GEN_FRAC_EN
        check("frac_four_period_sum", sum, 41);
`else
        check("frac_four_period_sum", sum, 40);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
